// File: rtl/uart_audio_framer_pkg.sv
// Shared constants, FSM state type and frame-length helper for uart_audio_framer.
// Optional checksum byte is enabled by defining UART_AUDIO_FRAMER_CHECKSUM_EN.
package uart_audio_framer_pkg;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

`ifdef UART_AUDIO_FRAMER_CHECKSUM_EN
  localparam int unsigned CHK_BYTES = 1;
  typedef enum logic [2:0] {ST_IDLE, ST_HEADER, ST_DATA, ST_CHK, ST_GAP} state_t;
`else
  localparam int unsigned CHK_BYTES = 0;
  typedef enum logic [2:0] {ST_IDLE, ST_HEADER, ST_DATA, ST_GAP} state_t;
`endif

  // Total bytes on the wire for one frame: header, enabled channel bytes, optional checksum.
  function automatic int unsigned frame_len(input logic [31:0] mask,
                                            input int unsigned channels,
                                            input int unsigned out_bytes);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < channels && mask[i]) n++;
    end
    return 1 + n * out_bytes + CHK_BYTES;
  endfunction

endpackage

// File: rtl/uart_audio_framer_if.sv
// Byte-wide transmit handshake between the framer (master) and the UART (slave).
interface uart_audio_framer_if;
  logic [7:0] tx_data_out;
  logic       tx_valid_out;
  logic       tx_busy_in;

  modport master (output tx_data_out, output tx_valid_out, input tx_busy_in);
  modport slave  (input tx_data_out, input tx_valid_out, output tx_busy_in);
endinterface

// File: rtl/uart_audio_framer_frame_fifo.sv
// Synchronous FIFO with full/empty flags and first-word-fall-through read data.
module frame_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/uart_audio_framer.sv
// Packs masked, truncated TDM samples into 0xA5-headed byte frames for a byte UART.
// Defining UART_AUDIO_FRAMER_CHECKSUM_EN appends an XOR checksum of the data bytes.
module uart_audio_framer
  import uart_audio_framer_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int SAMPLE_WIDTH = 24,
  parameter int OUT_BYTES    = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                    clk_in,
  input  logic                                    rst_n_in,
  input  logic [CHANNELS-1:0][SAMPLE_WIDTH-1:0]   audio_in,
  input  logic                                    audio_valid_in,
  input  logic                                    enable_in,
  input  logic [CHANNELS-1:0]                     channel_mask_in,
  uart_audio_framer_if.master                     tx,
  output logic [15:0]                             drop_count_out,
  output logic                                    frame_active_out
);
  localparam int SW8  = 8 * OUT_BYTES;
  localparam int DW   = CHANNELS * SW8;
  localparam int FW   = DW + CHANNELS;
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BY_W = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
  localparam logic [BY_W-1:0] BY_LAST = BY_W'(OUT_BYTES - 1);
  localparam logic [BY_W-1:0] BY_ONE  = BY_W'(1);
`ifdef UART_AUDIO_FRAMER_CHECKSUM_EN
  localparam state_t FRAME_END = ST_CHK;
`else
  localparam state_t FRAME_END = ST_IDLE;
`endif

  logic          vld_p0;
  logic          push_p1;
  logic [FW-1:0] cap_p1;
  logic [DW-1:0] trunc;
  logic          fifo_full, fifo_empty, pop;
  logic [FW-1:0] fifo_rd;

  state_t          state, state_n, gap_ret, gap_ret_n;
  logic [FW-1:0]   frame_q, frame_n;
  logic [CH_W-1:0] ch_idx, ch_n, nxt_ch, first_ch;
  logic [BY_W-1:0] byte_idx, by_n;
  logic [15:0]     data_left, left_n;
  logic [7:0]      chk_q, chk_n, cur_byte, txd_n;
  logic            txv_n;

  always_comb begin
    trunc = '0;
    for (int c = 0; c < CHANNELS; c++) trunc[c*SW8 +: SW8] = audio_in[c][SAMPLE_WIDTH-1 -: SW8];
  end

  // p0: edge detect on the level valid; p1: captured frame ready to write
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_p0         <= 1'b0;
      push_p1        <= 1'b0;
      drop_count_out <= '0;
    end else begin
      vld_p0  <= audio_valid_in;
      push_p1 <= audio_valid_in & ~vld_p0 & enable_in & (|channel_mask_in);
      if (push_p1 && fifo_full && drop_count_out != 16'hFFFF)
        drop_count_out <= drop_count_out + 16'd1;
    end
  end

  always_ff @(posedge clk_in) cap_p1 <= {channel_mask_in, trunc};

  frame_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_in), .rst_n(rst_n_in),
    .wr_en(push_p1), .wr_data(cap_p1), .full(fifo_full),
    .rd_en(pop), .rd_data(fifo_rd), .empty(fifo_empty)
  );

  // Byte selection from the latched snapshot
  always_comb begin
    cur_byte = '0;
    for (int c = 0; c < CHANNELS; c++)
      for (int b = 0; b < OUT_BYTES; b++)
        if (int'(ch_idx) == c && int'(byte_idx) == b)
          cur_byte = frame_q[c*SW8 + (OUT_BYTES-1-b)*8 +: 8];
  end

  always_comb begin
    nxt_ch   = ch_idx;
    first_ch = '0;
    for (int c = CHANNELS-1; c >= 0; c--) begin
      if (c > int'(ch_idx) && frame_q[DW+c]) nxt_ch = CH_W'(c);
      if (fifo_rd[DW+c]) first_ch = CH_W'(c);
    end
  end

  always_comb begin
    state_n   = state;
    gap_ret_n = gap_ret;
    frame_n   = frame_q;
    ch_n      = ch_idx;
    by_n      = byte_idx;
    left_n    = data_left;
    chk_n     = chk_q;
    txd_n     = tx.tx_data_out;
    txv_n     = 1'b0;
    pop       = 1'b0;
    case (state)
      ST_IDLE: if (!fifo_empty && !tx.tx_busy_in) begin
        pop     = 1'b1;
        frame_n = fifo_rd;
        ch_n    = first_ch;
        by_n    = '0;
        left_n  = 16'(frame_len(32'(fifo_rd[DW +: CHANNELS]), CHANNELS, OUT_BYTES) - 1 - CHK_BYTES);
        chk_n   = '0;
        state_n = ST_HEADER;
      end
      ST_HEADER: if (!tx.tx_busy_in) begin
        txv_n     = 1'b1;
        txd_n     = HEADER_BYTE;
        gap_ret_n = ST_DATA;
        state_n   = ST_GAP;
      end
      ST_DATA: if (!tx.tx_busy_in) begin
        txv_n  = 1'b1;
        txd_n  = cur_byte;
        chk_n  = chk_q ^ cur_byte;
        left_n = data_left - 16'd1;
        if (byte_idx == BY_LAST) begin
          by_n = '0;
          ch_n = nxt_ch;
        end else begin
          by_n = byte_idx + BY_ONE;
        end
        gap_ret_n = (data_left == 16'd1) ? FRAME_END : ST_DATA;
        state_n   = ST_GAP;
      end
`ifdef UART_AUDIO_FRAMER_CHECKSUM_EN
      ST_CHK: if (!tx.tx_busy_in) begin
        txv_n     = 1'b1;
        txd_n     = chk_q;
        gap_ret_n = ST_IDLE;
        state_n   = ST_GAP;
      end
`endif
      ST_GAP:  state_n = gap_ret;
      default: state_n = ST_IDLE;
    endcase
  end

  // Registered FSM state and outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state            <= ST_IDLE;
      gap_ret          <= ST_IDLE;
      ch_idx           <= '0;
      byte_idx         <= '0;
      data_left        <= '0;
      tx.tx_data_out   <= 8'h00;
      tx.tx_valid_out  <= 1'b0;
      frame_active_out <= 1'b0;
    end else begin
      state            <= state_n;
      gap_ret          <= gap_ret_n;
      ch_idx           <= ch_n;
      byte_idx         <= by_n;
      data_left        <= left_n;
      tx.tx_data_out   <= txd_n;
      tx.tx_valid_out  <= txv_n;
      frame_active_out <= (state_n != ST_IDLE);
    end
  end

  always_ff @(posedge clk_in) begin
    frame_q <= frame_n;
    chk_q   <= chk_n;
  end
endmodule

// File: doc/uart_audio_framer.md
# uart_audio_framer

Packs multi-channel microphone samples from the TDM receiver into framed byte streams for the byte-wide UART transmitter. Generalises the current fixed "channel 0, top 16 bits" path to any channel count, bytes-per-sample and runtime channel mask, and adds a frame FIFO, a sync header and drop accounting. Sits between `tdm_receive` and a one-byte UART transmitter, all in the 100 MHz system domain.

## Interface
- `CHANNELS`, 2: number of microphone channels presented.
- `SAMPLE_WIDTH`, 24: bits per input sample.
- `OUT_BYTES`, 2: bytes sent per channel; takes the MSBs `[SAMPLE_WIDTH-1 -: 8*OUT_BYTES]`, requires `8*OUT_BYTES <= SAMPLE_WIDTH`.
- `FIFO_DEPTH`, 4: captured frames buffered; power of two, at least 2.

Ports:
- `clk_in`  in  1  system clock, 100 MHz.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `audio_in`  in  `[CHANNELS][SAMPLE_WIDTH]`  samples from `tdm_receive`.
- `audio_valid_in`  in  1  level valid from the receiver. Its rising edge marks a new sample set.
- `enable_in`  in  1  capture enable.
- `channel_mask_in`  in  `CHANNELS`  bit i set means channel i is sent.
- `tx_data_out`  out  8  byte to the UART.
- `tx_valid_out`  out  1  single-cycle trigger to the UART.
- `tx_busy_in`  in  1  UART busy.
- `drop_count_out`  out  16  frames lost to a full FIFO. Saturates at 0xFFFF.
- `frame_active_out`  out  1  high while a frame is being emitted.

## Operation
- **Capture:** `audio_valid_in` is registered once internally. On each rising edge, with `enable_in` high and a nonzero `channel_mask_in`:
  - Push one entry into the FIFO: all channels truncated to `8*OUT_BYTES` bits, plus a mask snapshot.
  - If the mask is zero or `enable_in` is low, nothing is pushed and nothing is counted.
  - If the FIFO is full, the new frame is discarded and `drop_count_out` increments, saturating. Frames already queued are never overwritten.
- **Emit FSM states:** IDLE, HEADER, DATA, CHK (CHK exists only under the macro), GAP.
- **IDLE:**
  - If the FIFO is not empty, pop one entry, latch it, and go to HEADER.
  - `frame_active_out` is high in every state except IDLE.
- **HEADER:** send byte 0xA5.
- **DATA:**
  - Channels are sent in ascending index order, skipping masked-off channels.
  - Each channel sends `OUT_BYTES` bytes, MSB first.
  - After the last byte of the highest enabled channel, go to CHK if the macro is defined, otherwise back to IDLE.
- **Byte handshake:**
  - A byte is issued by driving `tx_data_out` and pulsing `tx_valid_out` for one cycle.
  - After each issue the FSM enters GAP for exactly one cycle and ignores `tx_busy_in`.
  - The next byte is issued on the first later cycle with `tx_busy_in` low.
- **Enable and mask changes:** deasserting `enable_in` or changing the mask mid-frame does not alter the frame in flight. It uses its snapshot.
- **Simultaneous capture edge and pop:** the push succeeds whenever the FIFO was not full before that cycle.
- **Reset (any time, including mid-frame):**
  - FIFO emptied, FSM to IDLE.
  - `tx_valid_out` 0, `tx_data_out` 0x00, `drop_count_out` 0, `frame_active_out` 0.
  - A partly sent frame is abandoned. The receiver resynchronises on 0xA5.

## Timing
- Capture edge to FIFO write: 2 cycles (1 for edge detection, 1 for the write).
- Non-empty FIFO with UART idle to the header's `tx_valid_out`: 2 cycles (pop/latch, then HEADER issue).
- Minimum byte spacing: 2 cycles, when `tx_busy_in` stays low.
- Frame length in bytes: 1 + (number of enabled channels × `OUT_BYTES`), plus 1 under the macro.
- All outputs are registered.

## Configuration
- **`UART_AUDIO_FRAMER_CHECKSUM_EN` defined:**
  - After the data bytes, one byte is sent: the XOR of all data bytes, header excluded.
  - A frame containing only 0x12 and 0x34 gives checksum 0x26.
- **Undefined:** no CHK state, and the frame ends after the last data byte.

## Structure
- Package `uart_audio_framer_pkg` holds:
  - `HEADER_BYTE` = 8'hA5.
  - The FSM state enum.
  - A function giving the frame byte count from the mask.
- Sub-module `frame_fifo`: a synchronous FIFO, parameterised by width and depth, with `full` and `empty` flags and the same clock and reset.
- The framer instantiates it with width `CHANNELS*8*OUT_BYTES + CHANNELS`.

## Test plan
- Defaults, mask 2'b01, ch0 = 24'h123456, UART idle:
  - Macro off: bytes A5, 12, 34, then IDLE.
  - Macro on: A5, 12, 34, 26.
- Mask 2'b10, ch0 = 24'hFFFFFF, ch1 = 24'hABCDEF -> bytes A5, AB, CD. Channel 0 is never sent.
- Hold `tx_busy_in` high and give 6 capture edges with mask 2'b11 -> 4 frames queued, `drop_count_out` = 2. After releasing busy, exactly 4 complete frames are emitted in capture order.
- Mask 2'b00, then `enable_in` low with a valid edge -> no `tx_valid_out`, `drop_count_out` stays 0.
- Assert `rst_n_in` low in the middle of DATA -> all outputs at their reset values in the same cycle, and the next frame after release starts with A5.
- Change the mask from 2'b11 to 2'b01 during the header of a frame -> that frame still carries both channels, and the next frame carries ch0 only.
